// File: rtl/cache_def.sv
// Shared definitions for the client-risk cache: CPU-port structs plus the
// command and verdict encodings used by the risk sequencer.
package cache_def;

  localparam int RISK_WORD_W = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  // Prefixed so the literals cannot collide with a TIMEOUT parameter in importers.
  typedef enum logic {
    RISK_ORDER     = 1'b0,
    RISK_SET_LIMIT = 1'b1
  } risk_op_e;

  typedef enum logic [1:0] {
    RISK_OK         = 2'd0,
    RISK_OVER_LIMIT = 2'd1,
    RISK_TIMEOUT    = 2'd2
  } risk_code_e;

endpackage

// File: rtl/trade_risk_sequencer_check.sv
// Combinational limit check: decides whether a command may be applied to a
// risk word {limit, accum} and forms the word to write back.
module risk_limit_check
  import cache_def::*;
#(
  parameter int QTY_W = 16
) (
  input  risk_op_e                op,
  input  logic [QTY_W-1:0]        limit,
  input  logic [QTY_W-1:0]        accum,
  input  logic [QTY_W-1:0]        qty,
  output logic                    pass,
  output logic [RISK_WORD_W-1:0]  new_word
);

  logic [QTY_W:0] sum;

  always_comb begin
    // NOTE: every output gets a default before the branch, so no latch is inferred.
    sum      = {1'b0, accum} + {1'b0, qty};
    pass     = 1'b1;
    new_word = {qty, accum};
    if (op == RISK_ORDER) begin
      // The carry bit makes any 16-bit overflow exceed every representable limit.
      pass     = (sum <= {1'b0, limit});
      new_word = {limit, sum[QTY_W-1:0]};
    end
  end

endmodule

// File: rtl/trade_risk_sequencer.sv
// Order/limit-update front-end of the client-risk cache: read the client's risk
// word, check it, write it back on success and return a verdict.
module trade_risk_sequencer
  import cache_def::*;
#(
  parameter int CLIENT_W = 10,
  parameter int QTY_W    = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ord_valid,
  output logic                ord_ready,
  input  logic                ord_op,
  input  logic [CLIENT_W-1:0] ord_client,
  input  logic [QTY_W-1:0]    ord_qty,
  output cpu_req_type         cpu_req,
  input  cpu_result_type      cpu_res,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_accept,
  output logic [1:0]          res_code,
  output logic [CLIENT_W-1:0] res_client,
  output logic [QTY_W-1:0]    res_accum,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DECIDE,
    S_WRITE,
    S_RESP
  } state_e;

  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e                 state;
  risk_op_e               op_q;
  logic [QTY_W-1:0]       qty_q;
  logic [RISK_WORD_W-1:0] word_q;
  logic [WD_W-1:0]        wd;
  logic                   pass;
  logic [RISK_WORD_W-1:0] new_word;

  risk_limit_check #(.QTY_W(QTY_W)) u_check (
    .op       (op_q),
    .limit    (word_q[RISK_WORD_W-1:QTY_W]),
    .accum    (word_q[QTY_W-1:0]),
    .qty      (qty_q),
    .pass     (pass),
    .new_word (new_word)
  );

  // NOTE: all state here is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cpu_req    <= '0;
      res_valid  <= 1'b0;
      res_accept <= 1'b0;
      res_code   <= RISK_OK;
      res_client <= '0;
      res_accum  <= '0;
      wd         <= '0;
      op_q       <= RISK_ORDER;
      qty_q      <= '0;
      word_q     <= '0;
      ord_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ord_valid) begin
            op_q          <= risk_op_e'(ord_op);
            qty_q         <= ord_qty;
            res_client    <= ord_client;
            cpu_req.addr  <= RISK_WORD_W'({ord_client, 4'b0000});
            cpu_req.data  <= '0;
            cpu_req.rw    <= 1'b0;
            cpu_req.valid <= 1'b1;
            wd            <= '0;
            ord_ready     <= 1'b0;
            busy          <= 1'b1;
            state         <= S_READ;
          end
        end

        S_READ: begin
          if (cpu_res.ready) begin
            word_q        <= cpu_res.data;
            cpu_req.valid <= 1'b0;
            state         <= S_DECIDE;
          end else if (wd == WD_LAST) begin
            cpu_req.valid <= 1'b0;
            res_code      <= RISK_TIMEOUT;
            res_accept    <= 1'b0;
            res_accum     <= '0;
            res_valid     <= 1'b1;
            state         <= S_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        // Idle gap on cpu_req.valid keeps the cache FSM from re-entering compare_tag.
        S_DECIDE: begin
          if (pass) begin
            cpu_req.data  <= new_word;
            cpu_req.rw    <= 1'b1;
            cpu_req.valid <= 1'b1;
            wd            <= '0;
            state         <= S_WRITE;
          end else begin
            res_code   <= RISK_OVER_LIMIT;
            res_accept <= 1'b0;
            res_accum  <= word_q[QTY_W-1:0];
            res_valid  <= 1'b1;
            state      <= S_RESP;
          end
        end

        S_WRITE: begin
          if (cpu_res.ready) begin
            cpu_req.valid <= 1'b0;
            res_code      <= RISK_OK;
            res_accept    <= 1'b1;
            res_accum     <= cpu_req.data[QTY_W-1:0];
            res_valid     <= 1'b1;
            state         <= S_RESP;
          end else if (wd == WD_LAST) begin
            cpu_req.valid <= 1'b0;
            res_code      <= RISK_TIMEOUT;
            res_accept    <= 1'b0;
            res_accum     <= word_q[QTY_W-1:0];
            res_valid     <= 1'b1;
            state         <= S_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end

        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ord_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
